// File: rtl/pc_sequencer_if.sv
// Interface between the control unit / ALU-zero logic and the next-PC
// sequencer. The master side raises requests and reads the fetch address;
// the slave side is the sequencer.
interface pc_sequencer_if #(
    parameter int PC_W     = 32,
    parameter int OFFSET_W = 8
);
    logic                IMEM_BUSYWAIT;
    logic                STALL;
    logic                JUMP;
    logic                BRANCH_TAKEN;
    logic [OFFSET_W-1:0] OFFSET;
    logic [PC_W-1:0]     PC;
    logic                PC_VALID;
    logic                REDIRECT;

    modport master (
        output IMEM_BUSYWAIT, STALL, JUMP, BRANCH_TAKEN, OFFSET,
        input  PC, PC_VALID, REDIRECT
    );

    modport slave (
        input  IMEM_BUSYWAIT, STALL, JUMP, BRANCH_TAKEN, OFFSET,
        output PC, PC_VALID, REDIRECT
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch program counter. Each cycle it selects a
// relative jump/branch target, holds the PC (stall or imem busywait), or
// increments. Redirects that arrive while imem is busy are parked in a
// pending slot and applied on the first cycle memory is ready.
// Optional feature macro: PC_SEQ_PERF_EN adds FETCH_CNT / HOLD_CNT.
module pc_sequencer #(
    parameter int              PC_W         = 32,
    parameter int              OFFSET_W     = 8,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
    input  logic         CLK,
    input  logic         RESET,
    pc_sequencer_if.slave bus
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [31:0]  FETCH_CNT,
    output logic [31:0]  HOLD_CNT
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic            pc_valid_q;
    logic            redirect_q;
    logic            pend_vld_q;
    logic [PC_W-1:0] pend_tgt_q;

    logic [PC_W-1:0] offset_ext;
    logic [PC_W-1:0] target;
    logic            redirect_req;
    logic            load_tgt;
    logic            load_pend;
    logic            load_inc;
    logic            park_req;

    // JUMP outranks BRANCH_TAKEN, but both share OFFSET, so the target is the
    // same whichever wins; only the fact that some redirect was asked matters.
    assign redirect_req = bus.JUMP | bus.BRANCH_TAKEN;

    // Signed word offset, sign-extended to the PC width; target wraps mod 2^PC_W.
    assign offset_ext = PC_W'($signed(bus.OFFSET));
    assign target     = pc_q + PC_W'(1) + offset_ext;

    // Decode which single PC action applies this cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        load_tgt  = 1'b0;
        load_pend = 1'b0;
        load_inc  = 1'b0;
        park_req  = 1'b0;
        if (state_q == RUN || state_q == WAIT) begin
            if (bus.IMEM_BUSYWAIT) begin
                park_req = redirect_req;
            end else if (redirect_req) begin
                load_tgt = 1'b1;
            end else if (state_q == WAIT && pend_vld_q) begin
                load_pend = 1'b1;
            end else if (!bus.STALL) begin
                load_inc = 1'b1;
            end
        end
    end

    // Sequencer FSM with registered PC, PC_VALID, REDIRECT and pending slot.
    always_ff @(posedge CLK) begin
        // NOTE: all sequential state uses non-blocking assignments so every
        // register sees the pre-edge values of its neighbours.
        if (!RESET) begin
            // NOTE: pend_tgt_q is data qualified by pend_vld_q, so it is
            // deliberately left out of reset; clearing the valid bit suffices.
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
            redirect_q <= 1'b0;
            pend_vld_q <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    // First fetch is from RESET_VECTOR itself.
                    state_q    <= RUN;
                    pc_valid_q <= 1'b1;
                    redirect_q <= 1'b0;
                end
                RUN, WAIT: begin
                    state_q    <= bus.IMEM_BUSYWAIT ? WAIT : RUN;
                    redirect_q <= load_tgt | load_pend;
                    if (park_req) begin
                        // Latest redirect during busywait wins.
                        pend_vld_q <= 1'b1;
                        pend_tgt_q <= target;
                    end else if (load_tgt | load_pend) begin
                        // A fresh redirect on the release cycle supersedes
                        // the parked one; either way the slot is consumed.
                        pend_vld_q <= 1'b0;
                    end
                    if (load_tgt) begin
                        pc_q <= target;
                    end else if (load_pend) begin
                        pc_q <= pend_tgt_q;
                    end else if (load_inc) begin
                        pc_q <= pc_q + PC_W'(1);
                    end
                end
                default: begin
                    state_q    <= BOOT;
                    pc_valid_q <= 1'b0;
                    redirect_q <= 1'b0;
                    pend_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PC       = pc_q;
    assign bus.PC_VALID = pc_valid_q;
    assign bus.REDIRECT = redirect_q;

`ifdef PC_SEQ_PERF_EN
    logic active;
    logic pc_load;

    assign active  = (state_q == RUN) || (state_q == WAIT);
    assign pc_load = load_tgt | load_pend | load_inc;

    // Saturating fetch/hold counters; every RUN/WAIT cycle bumps exactly one.
    // A PC load counts as a fetch change even if the target equals the old PC.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            FETCH_CNT <= '0;
            HOLD_CNT  <= '0;
        end else if (active) begin
            if (pc_load) begin
                if (FETCH_CNT != '1) FETCH_CNT <= FETCH_CNT + 32'd1;
            end else begin
                if (HOLD_CNT != '1) HOLD_CNT <= HOLD_CNT + 32'd1;
            end
        end
    end
`endif

endmodule
